// File: rtl/cmp_pipe_nb.sv
// Pipelined magnitude comparator: resolves CHUNK bits per stage, MSB chunk first,
// with a per-entry signed/unsigned mode, valid/ready handshakes and a saturating eq counter.
module cmp_pipe_nb #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] eq_count
);

   localparam int unsigned NSTG = WIDTH / CHUNK;
   localparam int unsigned LAST = NSTG - 1;

   logic             w_adv;
   logic [WIDTH-1:0] w_flip;
   logic             w_ov;
   logic             w_eq;
   logic [CNT_W-1:0] r_cnt;

   assign w_adv    = !w_ov | out_ready;
   assign in_ready = w_adv;
   // Flipping the MSB maps two's complement onto offset binary, so every stage compares unsigned.
   assign w_flip   = WIDTH'(is_signed) << (WIDTH - 1);

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int unsigned IN_W = WIDTH - k * CHUNK;

      logic [IN_W-1:0]  w_a;
      logic [IN_W-1:0]  w_b;
      logic [CHUNK-1:0] w_ca;
      logic [CHUNK-1:0] w_cb;
      logic             w_vin;
      logic             w_din;
      logic             w_gin;
      logic             w_lin;
      logic             r_vld;
      logic             r_dec;
      logic             r_gt;
      logic             r_lt;

      if (k == 0) begin : g_src
         assign w_a   = A ^ w_flip;
         assign w_b   = B ^ w_flip;
         assign w_vin = in_valid;
         assign w_din = 1'b0;
         assign w_gin = 1'b0;
         assign w_lin = 1'b0;
      end else begin : g_src
         assign w_a   = g_stg[k-1].g_fwd.r_a;
         assign w_b   = g_stg[k-1].g_fwd.r_b;
         assign w_vin = g_stg[k-1].r_vld;
         assign w_din = g_stg[k-1].r_dec;
         assign w_gin = g_stg[k-1].r_gt;
         assign w_lin = g_stg[k-1].r_lt;
      end

      assign w_ca = w_a[IN_W-1 -: CHUNK];
      assign w_cb = w_b[IN_W-1 -: CHUNK];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_vld <= 1'b0;
            r_dec <= 1'b0;
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
         end else if (w_adv) begin
            r_vld <= w_vin;
            r_dec <= w_din | (w_ca != w_cb);
            r_gt  <= w_din ? w_gin : (w_ca > w_cb);
            r_lt  <= w_din ? w_lin : (w_ca < w_cb);
         end
      end

      // Only the not-yet-compared lower chunks travel on to the next stage.
      if (k < LAST) begin : g_fwd
         logic [IN_W-CHUNK-1:0] r_a;
         logic [IN_W-CHUNK-1:0] r_b;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_a <= '0;
               r_b <= '0;
            end else if (w_adv) begin
               r_a <= w_a[IN_W-CHUNK-1:0];
               r_b <= w_b[IN_W-CHUNK-1:0];
            end
         end
      end
   end

   assign w_ov      = g_stg[LAST].r_vld;
   assign w_eq      = w_ov & !g_stg[LAST].r_dec;
   assign out_valid = w_ov;
   assign gt        = w_ov & g_stg[LAST].r_gt;
   assign lt        = w_ov & g_stg[LAST].r_lt;
   assign eq        = w_eq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (w_eq && out_ready && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign eq_count = r_cnt;

endmodule

// File: tb/tb_cmp_pipe_nb.sv
// Directed bench for cmp_pipe_nb: 16-bit/4-bit-chunk pipeline plus two single-stage 8-bit copies.
module tb_cmp_pipe_nb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, is_signed, out_valid, out_ready;
   logic        gt, eq, lt, cnt_clr;
   logic [15:0] A, B;
   logic [7:0]  eq_count;

   logic        v8;
   logic [7:0]  a8, b8;
   logic        s_rdy, s_ov, s_gt, s_eq, s_lt;
   logic        u_rdy, u_ov, u_gt, u_eq, u_lt;
   logic [7:0]  s_cnt, u_cnt;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cmp_pipe_nb #(.WIDTH(16), .CHUNK(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .is_signed(is_signed), .out_valid(out_valid), .out_ready(out_ready),
      .gt(gt), .eq(eq), .lt(lt), .cnt_clr(cnt_clr), .eq_count(eq_count));

   cmp_pipe_nb #(.WIDTH(8), .CHUNK(8), .CNT_W(8)) dut_s8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(s_rdy),
      .A(a8), .B(b8), .is_signed(1'b1), .out_valid(s_ov), .out_ready(1'b1),
      .gt(s_gt), .eq(s_eq), .lt(s_lt), .cnt_clr(1'b0), .eq_count(s_cnt));

   cmp_pipe_nb #(.WIDTH(8), .CHUNK(8), .CNT_W(8)) dut_u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(u_rdy),
      .A(a8), .B(b8), .is_signed(1'b0), .out_valid(u_ov), .out_ready(1'b1),
      .gt(u_gt), .eq(u_eq), .lt(u_lt), .cnt_clr(1'b0), .eq_count(u_cnt));

   // {gt,eq,lt} of a vs b, both w bits wide
   function automatic logic [2:0] ref_cmp(input logic [15:0] a, input logic [15:0] b,
                                          input int w, input logic s);
      longint va, vb;
      va = longint'(a);
      vb = longint'(b);
      if (s && a[w-1]) va = va - (longint'(1) << w);
      if (s && b[w-1]) vb = vb - (longint'(1) << w);
      if (va > vb)       return 3'b100;
      else if (va == vb) return 3'b010;
      else               return 3'b001;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] ra [20];
   logic [15:0] rb [20];
   logic        rs [20];
   logic [2:0]  q [$];
   logic [2:0]  held, expv;
   logic        held_v;
   int          sent, got;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; is_signed = 1'b0;
      out_ready = 1'b1; cnt_clr = 1'b0; v8 = 1'b0; a8 = '0; b8 = '0;

      #12;
      chk("rst_ov", out_valid, 0);
      chk("rst_res", {gt, eq, lt}, 3'b000);
      chk("rst_cnt", eq_count, 0);
      chk("rst_ov8", s_ov, 0);
      #1 rst_n = 1'b1;
      tick();
      chk("rdy_after_rst", in_ready, 1);

      // 1: unsigned 1234 < 1235, result on the 4th edge
      A = 16'h1234; B = 16'h1235; is_signed = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("t1_ov_edge3", out_valid, 0);
      tick();
      chk("t1_ov_edge4", out_valid, 1);
      chk("t1_res", {gt, eq, lt}, 3'b001);
      tick();
      chk("t1_ov_after", out_valid, 0);

      // 2: 8000 vs 0001 unsigned then signed, back to back
      A = 16'h8000; B = 16'h0001; is_signed = 1'b0; in_valid = 1'b1;
      tick();
      is_signed = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      chk("t2_ov0", out_valid, 1);
      chk("t2_unsigned", {gt, eq, lt}, 3'b100);
      tick();
      chk("t2_ov1", out_valid, 1);
      chk("t2_signed", {gt, eq, lt}, 3'b001);
      tick();
      chk("t2_ov_after", out_valid, 0);

      // 3: streaming against a toggling out_ready
      for (int i = 0; i < 20; i++) begin
         ra[i] = 16'($urandom);
         if (i % 5 == 0)      rb[i] = ra[i];
         else if (i % 5 == 1) rb[i] = ra[i] ^ (16'h1 << (i % 16));
         else                 rb[i] = 16'($urandom);
         rs[i] = 1'($urandom_range(0, 1));
      end
      sent = 0; got = 0; held_v = 1'b0; held = '0;
      for (int c = 0; c < 400 && got < 20; c++) begin
         out_ready = (c % 4 == 0) || (c % 4 == 3);
         in_valid  = (sent < 20);
         if (sent < 20) begin
            A = ra[sent]; B = rb[sent]; is_signed = rs[sent];
         end
         #1;
         if (held_v) chk("t3_hold", {out_valid, gt, eq, lt}, {1'b1, held});
         if (out_valid && out_ready) begin
            expv = (q.size() > 0) ? q.pop_front() : 3'b111;
            chk("t3_result", {gt, eq, lt}, expv);
            got++;
         end
         held_v = out_valid && !out_ready;
         held   = {gt, eq, lt};
         if (in_valid && in_ready) begin
            q.push_back(ref_cmp(A, B, 16, is_signed));
            sent++;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      chk("t3_got", got, 20);
      chk("t3_queue_empty", q.size(), 0);
      repeat (5) tick();
      chk("t3_no_dup", out_valid, 0);

      // 4: 300 equal pairs saturate eq_count, then clear against a live eq handshake
      A = 16'hFFFF; B = 16'hFFFF; is_signed = 1'b0;
      sent = 0; got = 0;
      for (int c = 0; c < 400 && got < 300; c++) begin
         in_valid = (sent < 300);
         if (out_valid) begin
            chk("t4_eq", {gt, eq, lt}, 3'b010);
            got++;
         end
         if (in_valid && in_ready) sent++;
         tick();
      end
      in_valid = 1'b0;
      chk("t4_got", got, 300);
      chk("t4_saturated", eq_count, 255);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 10 && !out_valid; k++) tick();
      chk("t4_ov_before_clr", out_valid, 1);
      chk("t4_still_255", eq_count, 255);
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("t4_clr_wins", eq_count, 0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 10 && !out_valid; k++) tick();
      tick();
      chk("t4_inc_from_0", eq_count, 1);

      // 5: async reset with one result stalled at the output and three more in flight
      out_ready = 1'b0; A = 16'h0005; B = 16'h0005; in_valid = 1'b1;
      repeat (4) tick();
      in_valid = 1'b0;
      chk("t5_ov_stalled", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_ov_in_rst", out_valid, 0);
      chk("t5_cnt_in_rst", eq_count, 0);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("t5_no_stale", out_valid, 0);
      end

      // 6: single-stage 8-bit copies
      a8 = 8'h7F; b8 = 8'h80; v8 = 1'b1;
      tick();
      chk("t6_ov1", s_ov, 1);
      chk("t6_7f_80_signed", {s_gt, s_eq, s_lt}, 3'b100);
      chk("t6_7f_80_unsigned", {u_gt, u_eq, u_lt}, 3'b001);
      for (int i = 0; i < 65536; i++) begin
         a8 = i[15:8];
         b8 = i[7:0];
         tick();
         chk("t6_sweep_s", {s_gt, s_eq, s_lt}, ref_cmp({8'h00, a8}, {8'h00, b8}, 8, 1'b1));
         chk("t6_sweep_u", {u_gt, u_eq, u_lt}, ref_cmp({8'h00, a8}, {8'h00, b8}, 8, 1'b0));
      end
      chk("t6_ov_end", u_ov, 1);
      v8 = 1'b0;
      tick();
      chk("t6_ov_drained", s_ov, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
